// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath width, packed control bundle and its NOP encoding.
// Imported by the ID/EX, EX, MEM and WB stages so every stage agrees on the bundle layout.
package pipe_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 8;
  localparam int REG_W  = 5;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // True when the bundle describes a load, i.e. its result is only known after MEM.
  function automatic logic ctrl_is_load(input ctrl_t c);
    return c.mem_rd;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard check between the instruction in a downstream slot and the one in decode.
// Purely combinational so a later EX/MEM stall check can reuse it unchanged.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_mem_rd,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  output logic             hz
);

  logic rd_nonzero;
  logic src_match;

  // Both source fields are compared even when the opcode ignores one; an extra stall is harmless.
  assign rd_nonzero = (ex_rd != '0);
  assign src_match  = (ex_rd == id_rs1) | (ex_rd == id_rs2);
  assign hz         = ex_valid & ex_mem_rd & rd_nonzero & id_valid & src_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decode fields and operands, inserts one bubble per load-use
// hazard, and honours EX flushes (kill) and downstream holds (freeze).
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              ex_flush,
  input  logic              ex_stall,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);
  import pipe_pkg::ctrl_t;
  import pipe_pkg::CTRL_NOP;
  import pipe_pkg::ctrl_is_load;

  localparam logic [CTRL_W-1:0] NOP = CTRL_W'(CTRL_NOP);

  logic ex_mem_rd;
  logic hz;
  logic cnt_full;

  // Front-end handshake: id_stall high means the decode slot was not consumed this edge and
  // must be presented again unchanged; low means it was taken (captured, or killed by a flush).
  assign ex_mem_rd = ctrl_is_load(ctrl_t'(ex_ctrl));
  assign cnt_full  = &bubble_cnt;
  assign id_stall  = rst & ~ex_flush & (ex_stall | hz);

  hazard_detect u_hazard_detect (
    .ex_valid  (ex_valid),
    .ex_mem_rd (ex_mem_rd),
    .ex_rd     (ex_rd),
    .id_valid  (id_valid),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .hz        (hz)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= NOP;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      bubble_cnt  <= '0;
    end else if (ex_flush) begin
      // Killed slot: data still loads so the flush path shares the capture muxing.
      ex_valid    <= 1'b0;
      ex_ctrl     <= NOP;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
    end else if (!ex_stall) begin
      if (hz) begin
        // Bubble: EX becomes invalid, which clears the hazard on the following cycle.
        ex_valid <= 1'b0;
        ex_ctrl  <= NOP;
        if (!cnt_full) begin
          bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
      end else begin
        ex_valid    <= id_valid;
        ex_ctrl     <= id_valid ? id_ctrl : NOP;
        ex_pc       <= id_pc;
        ex_rs1_data <= id_rs1_data;
        ex_rs2_data <= id_rs2_data;
        ex_imm      <= id_imm;
        ex_rs1      <= id_rs1;
        ex_rs2      <= id_rs2;
        ex_rd       <= id_rd;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed load-use/flush/hold scenarios plus a random capture stream,
// with a second instance using a 2-bit bubble counter to exercise saturation.
module tb_id_ex_stage;

  localparam logic [7:0] C_ADD = 8'h01;
  localparam logic [7:0] C_LW  = 8'h0D;
  localparam int         W     = 152;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [7:0]  id_ctrl;
  logic        ex_flush, ex_stall;

  logic        id_stall, ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [7:0]  ex_ctrl;
  logic [15:0] bubble_cnt;

  logic        s_id_stall, s_ex_valid;
  logic [31:0] s_ex_pc, s_ex_rs1_data, s_ex_rs2_data, s_ex_imm;
  logic [4:0]  s_ex_rs1, s_ex_rs2, s_ex_rd;
  logic [7:0]  s_ex_ctrl;
  logic [1:0]  s_bubble_cnt;

  logic [W:0]  exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_cnt = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .CTRL_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .ex_flush(ex_flush), .ex_stall(ex_stall), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.XLEN(32), .CTRL_W(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .ex_flush(ex_flush), .ex_stall(ex_stall), .id_stall(s_id_stall),
    .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_rs1_data(s_ex_rs1_data),
    .ex_rs2_data(s_ex_rs2_data), .ex_imm(s_ex_imm), .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2),
    .ex_rd(s_ex_rd), .ex_ctrl(s_ex_ctrl), .bubble_cnt(s_bubble_cnt)
  );

  task automatic check_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic v, input logic [7:0] c, input logic [4:0] r1,
      input logic [4:0] r2, input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] d1,
      input logic [31:0] d2, input logic [31:0] imm);
    return {v, c, r1, r2, rd, pc, d1, d2, imm};
  endfunction

  // Expected EX contents if the current decode slot is captured normally.
  function automatic logic [W-1:0] cap();
    return pack(id_valid, id_valid ? id_ctrl : 8'h00, id_rs1, id_rs2, id_rd, id_pc,
                id_rs1_data, id_rs2_data, id_imm);
  endfunction

  task automatic drive_id(input logic v, input logic [31:0] pc, input logic [4:0] r1,
      input logic [4:0] r2, input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
      input logic [31:0] imm, input logic [7:0] c);
    id_valid = v; id_pc = pc; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_ctrl = c;
  endtask

  task automatic drive_random();
    drive_id(1'($urandom_range(0, 1)), $urandom, 5'($urandom), 5'($urandom), 5'($urandom),
             $urandom, $urandom, $urandom, 8'($urandom) & 8'hFB);
  endtask

  // One clock: check id_stall, queue the expectation, then compare EX after the edge.
  // full=0 means only valid/ctrl are defined (bubble).
  task automatic step(input logic full, input logic [W-1:0] exp_regs, input logic exp_stall);
    logic [W:0]   e;
    logic [W-1:0] obs;
    #1;
    check_eq("id_stall", id_stall, exp_stall);
    exp_q.push_back({full, exp_regs});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 1, 0);
    end else begin
      e   = exp_q.pop_front();
      obs = pack(ex_valid, ex_ctrl, ex_rs1, ex_rs2, ex_rd, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm);
      if (e[W]) check_eq("ex_regs", obs, e[W-1:0]);
      else      check_eq("ex_valid_ctrl", obs[W-1:W-9], e[W-1:W-9]);
    end
    check_eq("bubble_cnt", bubble_cnt, exp_cnt);
    check_eq("bubble_cnt_sat", s_bubble_cnt, (exp_cnt > 3) ? 3 : exp_cnt);
    @(negedge clk);
  endtask

  logic [W-1:0] e_lw, e_prev, flushed;
  localparam logic [W-1:0] BUB = '0;

  initial begin
    rst = 1'b0;
    ex_flush = 1'($urandom_range(0, 1));
    ex_stall = 1'($urandom_range(0, 1));
    drive_random();
    step(1'b1, '0, 1'b0);
    drive_random();
    step(1'b1, '0, 1'b0);
    rst = 1'b1; ex_flush = 1'b0; ex_stall = 1'b0;

    drive_id(1, 32'h100, 1, 2, 3, 32'hDEADBEEF, 32'h11, 32'h4, C_ADD);
    step(1'b1, cap(), 1'b0);
    check_eq("cap_pc", ex_pc, 32'h100);
    check_eq("cap_rs1_data", ex_rs1_data, 32'hDEADBEEF);
    check_eq("cap_valid", ex_valid, 1'b1);

    drive_id(1, 32'h104, 1, 0, 5, 32'h1000, 0, 32'h8, C_LW);
    step(1'b1, cap(), 1'b0);
    drive_id(1, 32'h108, 5, 7, 6, 32'h55, 32'h77, 0, C_ADD);
    exp_cnt = 1;
    step(1'b0, BUB, 1'b1);
    step(1'b1, cap(), 1'b0);

    drive_id(1, 32'h10C, 1, 0, 0, 32'h20, 0, 0, C_LW);
    step(1'b1, cap(), 1'b0);
    drive_id(1, 32'h110, 0, 0, 6, 0, 0, 0, C_ADD);
    step(1'b1, cap(), 1'b0);
    drive_id(1, 32'h114, 1, 0, 5, 32'h30, 0, 0, C_LW);
    step(1'b1, cap(), 1'b0);
    drive_id(1, 32'h118, 7, 8, 6, 32'h70, 32'h80, 0, C_ADD);
    step(1'b1, cap(), 1'b0);

    drive_id(1, 32'h11C, 2, 0, 9, 32'h40, 0, 0, C_LW);
    step(1'b1, cap(), 1'b0);
    drive_id(1, 32'h120, 1, 9, 10, 32'h10, 32'h90, 0, C_ADD);
    exp_cnt = 2;
    step(1'b0, BUB, 1'b1);
    step(1'b1, cap(), 1'b0);

    drive_id(1, 32'h124, 1, 0, 5, 32'h50, 0, 0, C_LW);
    step(1'b1, cap(), 1'b0);
    drive_id(0, 32'h128, 5, 5, 6, 32'h66, 32'h67, 32'h68, C_ADD);
    step(1'b1, cap(), 1'b0);

    drive_id(1, 32'h12C, 1, 0, 5, 32'h60, 0, 0, C_LW);
    step(1'b1, cap(), 1'b0);
    drive_id(1, 32'h130, 5, 0, 6, 32'hA5, 32'h5A, 32'h3, C_ADD);
    ex_flush = 1'b1; ex_stall = 1'b1;
    flushed = cap();
    flushed[W-1:W-9] = '0;
    step(1'b1, flushed, 1'b0);
    ex_flush = 1'b0; ex_stall = 1'b0;
    step(1'b1, cap(), 1'b0);

    drive_id(1, 32'h134, 1, 0, 5, 32'h70, 0, 0, C_LW);
    e_lw = cap();
    step(1'b1, e_lw, 1'b0);
    drive_id(1, 32'h138, 5, 3, 6, 32'hB1, 32'hB2, 32'hB3, C_ADD);
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, e_lw, 1'b1);
    ex_stall = 1'b0;
    exp_cnt = 3;
    step(1'b0, BUB, 1'b1);
    step(1'b1, cap(), 1'b0);

    drive_id(1, 32'h13C, 1, 0, 5, 32'h80, 0, 0, C_LW);
    step(1'b1, cap(), 1'b0);
    drive_id(1, 32'h140, 3, 5, 6, 32'hC1, 32'hC2, 0, C_ADD);
    exp_cnt = 4;
    step(1'b0, BUB, 1'b1);
    step(1'b1, cap(), 1'b0);

    drive_id(1, 32'h144, 1, 0, 5, 32'h90, 0, 0, C_LW);
    step(1'b1, cap(), 1'b0);
    drive_id(1, 32'h148, 5, 0, 6, 32'hD1, 0, 0, C_ADD);
    ex_stall = 1'b1; rst = 1'b0;
    exp_cnt = 0;
    step(1'b1, '0, 1'b0);
    ex_stall = 1'b0; rst = 1'b1;
    e_prev = cap();
    step(1'b1, e_prev, 1'b0);

    for (int i = 0; i < 40; i++) begin
      drive_random();
      ex_stall = ($urandom_range(0, 3) == 0);
      if (ex_stall) begin
        step(1'b1, e_prev, 1'b1);
      end else begin
        e_prev = cap();
        step(1'b1, e_prev, 1'b0);
      end
    end
    ex_stall = 1'b0;

    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage pipelined CPU. It sits directly downstream of the register file. It captures the decoded instruction fields, together with the two register-file read operands, into the execute-stage register. It also detects load-use hazards, inserting one bubble and stalling the front end, and applies EX-stage flushes (taken branch/jump) and downstream holds.

## Interface
Parameters:
- XLEN, 32, datapath width
- CTRL_W, 8, width of packed control bundle (see Structure)
- CNT_W, 16, width of bubble counter

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-low
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  XLEN  PC of decode instruction
- id_rs1, id_rs2, id_rd  in  5  register addresses
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data, already aligned with the decode fields
- id_imm  in  XLEN  sign-extended immediate
- id_ctrl  in  CTRL_W  control bundle {alu_op[3:0], alu_src, mem_rd, mem_wr, reg_wr}
- ex_flush  in  1  taken branch/jump resolved in EX; kill decode slot
- ex_stall  in  1  downstream hold (multi-cycle memory); freeze EX register
- id_stall  out  1  hold PC and IF/ID register this cycle
- ex_valid  out  1  EX slot valid
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered copies
- ex_rs1, ex_rs2, ex_rd  out  5  registered copies, used for forwarding
- ex_ctrl  out  CTRL_W  registered control; forced to CTRL_NOP when invalid
- bubble_cnt  out  CNT_W  count of load-use bubbles inserted, saturating

## Operation
- Load-use hazard: `hz = ex_valid & ex_ctrl.mem_rd & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2))`.
  - id_rs1 and id_rs2 are compared unconditionally; unused source fields may cause harmless extra stalls.
- Posedge update priority, highest first:
  1. rst == 0: ex_valid = 0, ex_ctrl = CTRL_NOP, all data/address outputs = 0, bubble_cnt = 0.
  2. ex_flush: ex_valid = 0, ex_ctrl = CTRL_NOP. Data fields are don't-care but are loaded from inputs. Flush overrides ex_stall and hz.
  3. ex_stall: all EX registers hold their value.
  4. hz: insert bubble. ex_valid = 0, ex_ctrl = CTRL_NOP, bubble_cnt += 1 (saturates at all-ones).
  5. Otherwise: capture all id_* fields. ex_valid = id_valid; ex_ctrl = id_valid ? id_ctrl : CTRL_NOP.
- `id_stall = rst & ~ex_flush & (ex_stall | hz)`. This signal is combinational.
- Register x0 never triggers a hazard.
- A bubble clears the hazard on the next cycle, so every load-use stall lasts exactly 1 cycle.
- No forwarding muxes live here. ex_rs1/ex_rs2 are exported for the forwarding unit.

## Timing
- Capture latency: 1 cycle. id_* values present at edge N appear on ex_* after edge N.
- id_stall is valid in the same cycle as the id_* inputs. It depends only on current inputs and EX registers.
- Load followed immediately by a dependent instruction: exactly 1 bubble. The dependent instruction enters EX one cycle later.
- ex_stall held k cycles: EX frozen k cycles, id_stall high k cycles, no bubble counted.
- ex_stall and hz in the same cycle: the hold wins. The hazard is re-evaluated after the release and yields one bubble.
- ex_flush and hz in the same cycle: flush wins, id_stall = 0, bubble_cnt unchanged.
- Reset asserted mid-stall: the next edge fully clears state. id_stall is 0 while rst == 0.

## Structure
- Shared package pipe_pkg holds:
  - CTRL_W
  - ctrl_t packed struct: alu_op, alu_src, mem_rd, mem_wr, reg_wr
  - CTRL_NOP = '0
  - XLEN
- The execute, memory and writeback stages import the same package.
- One combinational sub-module, hazard_detect, computes hz from the ex_* and id_* address/valid/ctrl signals. It is reusable by a later EX/MEM stall check.

## Test plan
- Reset: hold rst = 0 for 2 cycles with random inputs -> ex_valid = 0, ex_ctrl = 0, bubble_cnt = 0, id_stall = 0.
- Straight-line capture: id_pc = 0x100, id_rs1_data = 0xDEADBEEF, id_ctrl with reg_wr -> next cycle ex_pc = 0x100, ex_rs1_data = 0xDEADBEEF, ex_valid = 1.
- Load-use: lw x5 in EX, decode add x6,x5,x7 -> id_stall = 1 for 1 cycle, ex_valid = 0 for 1 cycle, bubble_cnt = 1, then add enters EX.
- x0 and no dependency: lw x0 followed by add using x0, and lw x5 followed by add x6,x7,x8 -> id_stall = 0, no bubble.
- Flush priority: ex_flush = 1 together with a hazard and ex_stall -> ex_valid = 0, id_stall = 0, bubble_cnt unchanged.
- Hold: ex_stall = 1 for 3 cycles during a hazard -> EX outputs stable for 3 cycles, then exactly 1 bubble, bubble_cnt += 1. A separate run preloads bubble_cnt at 0xFFFF -> it stays 0xFFFF.
